lsu_mem_master: RTL and testbench

Initiator side of the single-port memory interface: the load/store unit's memory request engine.
- Accepts one load or store at a time from the core over a valid/ready request channel.
- Drives the memory strobe/address/data/mask signals and waits for the memory's valid pulse.
- Aligns and extends load data, then returns a response over a valid/ready response channel.
- Sits between EXU/LSU control and the sram responder.

---
 rtl/lsu_mem_master.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store unit memory request engine. Accepts one load or
//               store at a time from the core, drives the single-port memory
//               strobes with lane-formatted address/data/mask, waits for the
//               memory completion pulse (with optional timeout), aligns and
//               extends load data, and returns a response to the core.
// Ports       : clk, rst (async, active-low)
//               req_*  : core request channel (valid/ready)
//               resp_* : core response channel (valid/ready)
//               mem_*  : memory initiator signals
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  // Last counter value before the timeout fires (only meaningful if TIMEOUT!=0)
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic             r_wen;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_misalign;
  logic             w_to_hit;
  logic             w_access;
  logic [1:0]       w_off;
  logic [4:0]       w_shamt;
  logic [31:0]      w_sh;
  logic [31:0]      w_load;
  logic [7:0]       w_wmask;
  logic [31:0]      w_wdata;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_accept   = req_valid && req_ready;
  assign w_misalign = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_to_hit   = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  // --------------------------------------------------------------------------
  // Lane formatting from the latched request
  // --------------------------------------------------------------------------
  assign w_off   = r_addr[1:0];
  assign w_shamt = {w_off, 3'b000};
  assign w_sh    = mem_rdata >> w_shamt;

  always_comb begin
    w_load  = mem_rdata;
    w_wmask = 8'h0F;
    w_wdata = r_wdata;
    case (r_size)
      2'd0: begin
        w_load  = r_uns ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
        w_wmask = 8'h01 << w_off;
        w_wdata = {24'h0, r_wdata[7:0]} << w_shamt;
      end
      2'd1: begin
        w_load  = r_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
        w_wmask = 8'h03 << w_off;
        w_wdata = {16'h0, r_wdata[15:0]} << w_shamt;
      end
      default: begin
        w_load  = mem_rdata;
        w_wmask = 8'h0F;
        w_wdata = r_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state. mem_valid takes priority over the timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_accept) w_state_nxt = w_misalign ? c_RESP : c_ACCESS;
      c_ACCESS: if (mem_valid || w_to_hit) w_state_nxt = c_RESP;
      c_RESP:   if (resp_ready) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Latched request, timeout counter and response payload
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if ((r_state == c_IDLE) && w_accept) begin
      r_wen   <= req_wen;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
      r_err   <= w_misalign;
    end else if (r_state == c_ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
      if (mem_valid) begin
        r_err   <= 1'b0;
        r_rdata <= r_wen ? 32'h0 : w_load;
      end else if (w_to_hit) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  assign w_access = (r_state == c_ACCESS);

  always_comb begin
    // req_ready is held low for the whole reset assertion, not just until
    // the state register has cleared.
    req_ready  = rst && (r_state == c_IDLE);
    // The strobes drop in the completion cycle itself so a responder that
    // answers one cycle after the strobe sees a single-cycle request.
    mem_ren    = w_access && !r_wen && !mem_valid;
    mem_wen    = w_access &&  r_wen && !mem_valid;
    mem_wmask  = mem_wen  ? w_wmask : 8'h00;
    mem_addr   = w_access ? {r_addr[31:2], 2'b00} : 32'h0;
    mem_wdata  = w_access ? w_wdata : 32'h0;
    resp_valid = (r_state == c_RESP);
    resp_err   = resp_valid && r_err;
    resp_rdata = resp_valid ? r_rdata : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed self-checking bench for lsu_mem_master. Expected
//               responses are queued when a request is issued and compared
//               when the response appears. A small responder model answers
//               strobes one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_valid;

  logic mem_auto = 1'b1;
  logic mv_auto  = 1'b0;
  logic mv_man   = 1'b0;
  int   ren_cnt  = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign mem_valid = mv_auto | mv_man;

  // Responder: completion pulse one cycle after a strobe is sampled.
  always @(posedge clk) begin
    mv_auto <= mem_auto && (mem_ren || mem_wen);
    if (mem_ren) ren_cnt <= ren_cnt + 1;
  end

  lsu_mem_master #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic send(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input bit push);
    exp_t e;
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
    end
  endtask

  // Waits for resp_valid, optionally holds off resp_ready, compares against the
  // scoreboard head, then completes the handshake.
  task automatic wait_resp(input string tag, input int exp_lat, input int hold);
    int   n = 0;
    exp_t e;
    e.rdata = 32'hx;
    e.err   = 1'bx;
    while (resp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_sb"}, 32'(sb.size()), 32'h1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'h0, resp_valid}, 32'h1);
      chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_hold_rdy"}, {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_done"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int r0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_strobes", {30'h0, mem_ren, mem_wen}, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wmask", {24'h0, mem_wmask}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Load word with one-cycle latency responder
    mem_rdata = 32'hDEAD_BEEF;
    r0 = ren_cnt;
    send(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("ldw_ren", {31'h0, mem_ren}, 32'h1);
    chk("ldw_addr", mem_addr, 32'h8000_0004);
    wait_resp("ldw", 2, 0);
    chk("ldw_ren_cycles", 32'(ren_cnt - r0), 32'h1);

    // Byte / half loads with extension
    mem_rdata = 32'h80FF_1234;
    send(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
    wait_resp("lbs", 2, 0);
    send(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'h0, 32'h0000_0080, 1'b0, 1'b1);
    wait_resp("lbu", 2, 0);
    send(1'b0, 2'd1, 1'b1, 32'h1000_0002, 32'h0, 32'h0000_80FF, 1'b0, 1'b1);
    wait_resp("lhu", 2, 0);
    send(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b1);
    wait_resp("lhs", 2, 0);
    send(1'b0, 2'd0, 1'b0, 32'h1000_0001, 32'h0, 32'h0000_0012, 1'b0, 1'b1);
    wait_resp("lb1", 2, 0);

    // Stores with lane formatting
    send(1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h0000_ABCD, 32'h0, 1'b0, 1'b1);
    chk("sh_wen", {30'h0, mem_wen, mem_ren}, 32'h2);
    chk("sh_wmask", {24'h0, mem_wmask}, 32'h0000_000C);
    chk("sh_wdata", mem_wdata, 32'hABCD_0000);
    chk("sh_addr", mem_addr, 32'h1000_0000);
    wait_resp("sh", 2, 0);
    send(1'b1, 2'd0, 1'b0, 32'h2000_0001, 32'h1234_5655, 32'h0, 1'b0, 1'b1);
    chk("sb_wmask", {24'h0, mem_wmask}, 32'h0000_0002);
    chk("sb_wdata", mem_wdata, 32'h0000_5500);
    wait_resp("sb", 2, 0);
    send(1'b1, 2'd2, 1'b0, 32'h2000_0008, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b1);
    chk("sw_wmask", {24'h0, mem_wmask}, 32'h0000_000F);
    chk("sw_wdata", mem_wdata, 32'hA5A5_5A5A);
    wait_resp("sw", 2, 0);

    // Misaligned and illegal-size requests: no strobe, immediate error
    r0 = ren_cnt;
    send(1'b0, 2'd2, 1'b0, 32'h1000_0001, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("mis_ren", {31'h0, mem_ren}, 32'h0);
    wait_resp("misw", 0, 0);
    send(1'b0, 2'd1, 1'b0, 32'h1000_0003, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_resp("mish", 0, 0);
    send(1'b0, 2'd3, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_resp("size3", 0, 0);
    chk("mis_ren_cycles", 32'(ren_cnt - r0), 32'h0);

    // Timeout (TIMEOUT=4) followed by a late, ignored mem_valid pulse
    mem_auto = 1'b0;
    r0 = ren_cnt;
    send(1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_resp("to", 4, 0);
    chk("to_ren_cycles", 32'(ren_cnt - r0), 32'h4);
    mv_man = 1'b1;
    @(negedge clk);
    mv_man = 1'b0;
    chk("late_resp", {31'h0, resp_valid}, 32'h0);
    chk("late_rdy", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    chk("late_resp2", {31'h0, resp_valid}, 32'h0);
    mem_auto = 1'b1;

    // Backpressure: response held for 5 cycles
    mem_rdata = 32'hCAFE_F00D;
    send(1'b0, 2'd2, 1'b0, 32'h4000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    wait_resp("bp", 2, 5);

    // Reset asserted mid-ACCESS
    mem_auto = 1'b0;
    send(1'b0, 2'd2, 1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("ra_ren_pre", {31'h0, mem_ren}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("ra_ren_drop", {31'h0, mem_ren}, 32'h0);
    chk("ra_addr_drop", mem_addr, 32'h0);
    chk("ra_rdy", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mem_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ra_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    mem_rdata = 32'h1357_9BDF;
    send(1'b0, 2'd2, 1'b0, 32'h5000_0004, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    wait_resp("ra_new", 2, 0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
